// File: rtl/object_spawner.sv
// Spawn parameter generator: LFSR-randomised launch data after a random tick delay.
// Optional spawn counter port enabled by defining SPAWN_COUNT_EN.
module object_spawner #(
   parameter int          DEPTH_BIT     = 18,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          MIN_DELAY     = 8,
   parameter logic [7:0]  DELAY_MASK    = 8'h3F,
   parameter int          START_Y       = 375,
   parameter int          SPRITE_STRIDE = 8000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 req,
   input  logic                 ack,
   output logic                 valid,
   output logic [9:0]           initposx,
   output logic [9:0]           initposy,
   output logic [DEPTH_BIT-1:0] addr,
   output logic [9:0]           initvx,
   output logic [9:0]           initvy,
   output logic                 initdx
`ifdef SPAWN_COUNT_EN
   ,
   output logic [7:0]           spawn_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READY
   } state_t;

   localparam logic [DEPTH_BIT-1:0] ADDR1 = DEPTH_BIT'(SPRITE_STRIDE);
   localparam logic [DEPTH_BIT-1:0] ADDR2 = DEPTH_BIT'(2 * SPRITE_STRIDE);
   localparam logic [DEPTH_BIT-1:0] ADDR3 = DEPTH_BIT'(3 * SPRITE_STRIDE);

   state_t               r_state;
   logic [15:0]          r_lfsr;
   logic [8:0]           r_cnt;
   logic                 r_valid;
   logic [9:0]           r_posx;
   logic [9:0]           r_posy;
   logic [9:0]           r_vx;
   logic [9:0]           r_vy;
   logic                 r_dx;
   logic [DEPTH_BIT-1:0] r_addr;

   logic [15:0]          w_lfsr_next;
   logic [8:0]           w_cnt_load;
   logic [9:0]           w_posx;
   logic [9:0]           w_vx;
   logic [9:0]           w_vy;
   logic [DEPTH_BIT-1:0] w_addr;

   // Galois form: shift right, fold the tap mask in when bit 0 falls out
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_cnt_load  = 9'(MIN_DELAY) + {1'b0, r_lfsr[7:0] & DELAY_MASK};
   assign w_posx      = 10'd16 + {1'b0, r_lfsr[8:0]};
   assign w_vx        = 10'd1 + {8'd0, r_lfsr[10:9]};
   assign w_vy        = 10'd4 + {8'd0, r_lfsr[12:11]};

   always_comb begin
      w_addr = '0;
      unique case (r_lfsr[14:13])
         2'd0:    w_addr = '0;
         2'd1:    w_addr = ADDR1;
         2'd2:    w_addr = ADDR2;
         default: w_addr = ADDR3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lfsr  <= LFSR_SEED;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_posx  <= '0;
         r_posy  <= '0;
         r_vx    <= '0;
         r_vy    <= '0;
         r_dx    <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_lfsr <= w_lfsr_next;
         unique case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_cnt   <= w_cnt_load;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tick) begin
                  if (r_cnt > 9'd1) begin
                     r_cnt <= r_cnt - 9'd1;
                  end else begin
                     r_posx  <= w_posx;
                     r_dx    <= (w_posx < 10'd320);
                     r_vx    <= w_vx;
                     r_vy    <= w_vy;
                     r_posy  <= 10'(START_Y);
                     r_addr  <= w_addr;
                     r_valid <= 1'b1;
                     r_state <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (ack) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef SPAWN_COUNT_EN
   logic [7:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (r_valid && ack) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign spawn_count = r_count;
`endif

   assign valid    = r_valid;
   assign initposx = r_posx;
   assign initposy = r_posy;
   assign initvx   = r_vx;
   assign initvy   = r_vy;
   assign initdx   = r_dx;
   assign addr     = r_addr;

endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner with an LFSR reference model and a
// scoreboard of predicted spawn parameter sets.
module tb_object_spawner;

   localparam int          MIN_D  = 8;
   localparam logic [7:0]  MASK   = 8'h3F;
   localparam int          SY     = 375;
   localparam int          STRIDE = 8000;
   localparam logic [15:0] SEED   = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        req = 1'b0;
   logic        ack = 1'b0;
   logic        valid;
   logic [9:0]  initposx;
   logic [9:0]  initposy;
   logic [17:0] addr;
   logic [9:0]  initvx;
   logic [9:0]  initvy;
   logic        initdx;
`ifdef SPAWN_COUNT_EN
   logic [7:0]  spawn_count;
`endif

   typedef struct packed {
      logic [9:0]  px;
      logic [9:0]  py;
      logic [9:0]  vx;
      logic [9:0]  vy;
      logic        dx;
      logic [17:0] addr;
   } exp_t;

   exp_t        q[$];
   exp_t        last_e;
   int          n_chk = 0;
   int          n_fail = 0;
   int          sc_exp = 0;
   logic [15:0] m_lfsr;
   logic [3:0]  addr_seen = '0;

   object_spawner dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .req      (req),
      .ack      (ack),
      .valid    (valid),
      .initposx (initposx),
      .initposy (initposy),
      .addr     (addr),
      .initvx   (initvx),
      .initvy   (initvy),
      .initdx   (initdx)
`ifdef SPAWN_COUNT_EN
      ,
      .spawn_count (spawn_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   function automatic exp_t predict(input logic [15:0] l);
      exp_t e;
      e.px   = 10'd16 + 10'(l[8:0]);
      e.dx   = (e.px < 10'd320);
      e.vx   = 10'd1 + 10'(l[10:9]);
      e.vy   = 10'd4 + 10'(l[12:11]);
      e.py   = 10'(SY);
      e.addr = 18'(int'(l[14:13]) * STRIDE);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [58:0] outs();
      return {initposx, initposy, initvx, initvy, initdx, addr};
   endfunction

   task automatic check_spawn(input exp_t e);
      chk("posx", initposx, e.px);
      chk("posy", initposy, e.py);
      chk("vx", initvx, e.vx);
      chk("vy", initvy, e.vy);
      chk("dx", initdx, e.dx);
      chk("addr", addr, e.addr);
      chk("posx_rng", (initposx >= 16 && initposx <= 527), 1);
      chk("dx_rule", initdx, (initposx < 320));
      chk("vx_rng", (initvx >= 1 && initvx <= 4), 1);
      chk("vy_rng", (initvy >= 4 && initvy <= 7), 1);
      case (addr)
         18'd0:     addr_seen[0] = 1'b1;
         18'd8000:  addr_seen[1] = 1'b1;
         18'd16000: addr_seen[2] = 1'b1;
         18'd24000: addr_seen[3] = 1'b1;
         default:   chk("addr_set", addr, 0);
      endcase
   endtask

   // Request a spawn, then drive exactly the predicted number of ticks.
   task automatic do_spawn(input bit tick_at_req, input bit hold_req, input int maxgap);
      int cnt;
      req  = 1'b1;
      tick = tick_at_req;
      cnt  = MIN_D + int'(m_lfsr[7:0] & MASK);
      step();
      tick = 1'b0;
      req  = hold_req;
      chk("wait_valid0", valid, 0);
      for (int k = 1; k <= cnt; k++) begin
         repeat ($urandom_range(maxgap, 0)) step();
         tick = 1'b1;
         if (k == cnt) q.push_back(predict(m_lfsr));
         step();
         tick = 1'b0;
         if (k < cnt) begin
            chk("early_valid", valid, 0);
         end else begin
            chk("valid_rise", valid, 1);
            last_e = q.pop_front();
            check_spawn(last_e);
         end
      end
      req = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
      sc_exp++;
      chk("ack_valid0", valid, 0);
`ifdef SPAWN_COUNT_EN
      chk("spawn_count", spawn_count, sc_exp % 256);
`endif
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) step();
      chk("rst_valid", valid, 0);
      chk("rst_posx", initposx, 0);
      chk("rst_addr", addr, 0);
      chk("rst_outs", outs(), 0);
      chk("rst_lfsr", dut.r_lfsr, SEED);
`ifdef SPAWN_COUNT_EN
      chk("rst_count", spawn_count, 0);
`endif
      rst = 1'b0;

      // tick coincident with req is not counted; then hold without ack
      do_spawn(1'b1, 1'b0, 3);
      for (int i = 0; i < 100; i++) begin
         tick = i[0];
         step();
         chk("hold", {valid, outs()}, {1'b1, last_e});
      end
      tick = 1'b0;
      do_ack();

      // ack while idle is ignored
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("idle_ack_valid", valid, 0);
      chk("idle_ack_outs", outs(), last_e);
`ifdef SPAWN_COUNT_EN
      chk("idle_ack_count", spawn_count, sc_exp % 256);
`endif

      // req held through WAIT and READY gives a single spawn
      do_spawn(1'b0, 1'b1, 2);
      req = 1'b1;
      repeat (5) step();
      req = 1'b0;
      chk("ready_req_valid", valid, 1);
      do_ack();
      tick = 1'b1;
      repeat (80) step();
      tick = 1'b0;
      chk("single_spawn", valid, 0);

      // reset during WAIT discards the pending spawn
      req = 1'b1;
      step();
      req = 1'b0;
      tick = 1'b1;
      repeat (3) step();
      tick = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", valid, 0);
      chk("midrst_lfsr", dut.r_lfsr, SEED);
      tick = 1'b1;
      repeat (100) step();
      tick = 1'b0;
      chk("midrst_nospawn", valid, 0);
`ifdef SPAWN_COUNT_EN
      sc_exp = 0;
      chk("midrst_count", spawn_count, 0);
`endif

      // randomised sweep
      for (int i = 0; i < 300; i++) begin
         do_spawn(1'($urandom_range(1, 0)), 1'b0, 2);
         do_ack();
         repeat ($urandom_range(3, 0)) begin
            tick = 1'($urandom_range(1, 0));
            step();
         end
         tick = 1'b0;
      end
      chk("addr_all_seen", addr_seen, 4'hF);
      chk("queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/object_spawner.md
Name: object_spawner

Overview:
- Upstream stage of the object state machine. Produces randomised launch parameters for each new sprite: start position, velocity, horizontal direction and sprite memory base address.
- Inserts a random delay between spawns, measured in motion ticks.
- Hands each parameter set over with a valid/ack handshake. The consumer raises req when its object leaves the screen and pulses ack when it has latched the parameters.

Parameters:
- DEPTH_BIT, 18, width of sprite memory address.
- LFSR_SEED, 16'hACE1, reset value of LFSR; must be nonzero.
- MIN_DELAY, 8, minimum spawn delay in ticks; must be >=1.
- DELAY_MASK, 8'h3F, mask applied to LFSR bits [7:0] to form the random extra delay.
- START_Y, 375, initial vertical position.
- SPRITE_STRIDE, 8000, address spacing between the 4 sprite images.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle pulse at the motion rate; the delay counter counts these
- req  in  1  consumer requests a new spawn (level or pulse; sampled only in IDLE)
- ack  in  1  consumer has latched the outputs; effective only while valid=1
- valid  out  1  outputs hold a spawn parameter set
- initposx  out  10  initial x position
- initposy  out  10  initial y position
- addr  out  DEPTH_BIT  sprite memory start address
- initvx  out  10  initial x speed magnitude
- initvy  out  10  initial y speed magnitude
- initdx  out  1  x direction; 1 = +x
- spawn_count  out  8  number of accepted spawns (present only with macro, see Optional Feature)

Behaviour:
- Reset: state IDLE, valid=0, all parameter outputs 0, delay counter 0, lfsr=LFSR_SEED.
- Reset mid-operation aborts to the same reset state; any pending spawn is discarded.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (toggle mask 16'hB400). Advances every clk while not in reset, regardless of state.

State machine:
- IDLE -> WAIT when req=1. In that cycle, load cnt = MIN_DELAY + (lfsr[7:0] & DELAY_MASK). The value is 9 bits wide, with no overflow for the default parameters.
- WAIT: on each tick with cnt>1, decrement cnt. On a tick with cnt==1, register the parameters from the current lfsr value, set valid=1 and go to READY. No tick means no change.
- Resulting delay: exactly cnt ticks after the req cycle. A tick in the same cycle as the accepted req is not counted.
- READY: valid=1 and all outputs held stable until ack=1. On ack, next cycle: valid=0, state IDLE, parameter outputs retain their last values.
- A req in the same cycle as ack is ignored, because req is sampled only in IDLE.

Parameter derivation (all from the single lfsr snapshot taken at the READY transition):
- initposx = 16 + lfsr[8:0], range 16..527; right edge stays below 640 for 100-px sprites.
- initdx = (initposx < 320) ? 1 : 0, so the object moves toward the centre.
- initvx = 1 + lfsr[10:9], range 1..4.
- initvy = 4 + lfsr[12:11], range 4..7.
- initposy = START_Y.
- addr = lfsr[14:13] * SPRITE_STRIDE, truncated to DEPTH_BIT bits; values 0, 8000, 16000, 24000.

Ignored inputs:
- req outside IDLE.
- ack outside READY.
- tick outside WAIT.

Optional Feature:
- Macro: SPAWN_COUNT_EN.
- Defined: adds port spawn_count[7:0]. Reset to 0; increments by 1 on each cycle with valid&ack. Wraps 255->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst 3 cycles -> valid=0, initposx=0, addr=0, internal lfsr=16'hACE1.
- Fixed delay: DELAY_MASK=0, MIN_DELAY=2, req pulse, ticks every 10 clk -> valid rises on the clk of the 2nd tick after req, not earlier. Also: a tick coincident with req is not counted.
- Hold/ack: enter READY, withhold ack 100 cycles -> outputs bit-stable, valid=1. Pulse ack -> valid=0 next cycle, state IDLE. A second ack while idle does nothing.
- Ignored req and mid-operation reset: req asserted continuously during WAIT -> single spawn only. rst asserted in WAIT -> valid=0, no spawn until a new req.
- Range sweep: 1000 req/ack cycles with random tick gaps. Every spawn: initposx in 16..527, initdx==(initposx<320), initvx in 1..4, initvy in 4..7, initposy==375, addr in {0,8000,16000,24000}. All 4 addr values must occur.
- SPAWN_COUNT_EN: 257 accepted handshakes -> spawn_count==1. No increment on ack without valid.
